// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: data first,
// a starvation guard for fetch, and a per-transaction watchdog with a sticky error flag.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);
    localparam int STREAK_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TIMEOUT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} arbState_t;

    arbState_t            state;
    arbState_t            nextState;
    logic [STREAK_W-1:0]  streak;
    logic [TIMEOUT_W-1:0] busyCount;
    logic                 busy;
    logic                 starveBlock;
    logic                 grantData;
    logic                 grantInst;
    logic                 timeoutHit;
    logic                 done;

    // Fetch wins only once data has taken STARVE_LIMIT grants in a row over it.
    assign busy        = (state == BUSY_I) || (state == BUSY_D);
    assign starveBlock = inst_req && (streak == STREAK_W'(STARVE_LIMIT));
    assign grantData   = (state == IDLE) && data_req && !starveBlock;
    assign grantInst   = (state == IDLE) && inst_req && !grantData;
    assign timeoutHit  = (busyCount == TIMEOUT_W'(TIMEOUT - 1));
    assign done        = busy && (mem_ready || timeoutHit);

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values, independent of process evaluation order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves nextState
        // unassigned and no latch is inferred.
        nextState = state;
        case (state)
            IDLE: begin
                if (grantData) begin
                    nextState = BUSY_D;
                end else if (grantInst) begin
                    nextState = BUSY_I;
                end
            end
            BUSY_I:  if (done) nextState = RESP_I;
            BUSY_D:  if (done) nextState = RESP_D;
            RESP_I:  nextState = IDLE;
            RESP_D:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        mem_req = busy;
        inst_ok = (state == RESP_I);
        data_ok = (state == RESP_D);
    end

    // Command latch, streak and watchdog counters, response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            bus_err    <= 1'b0;
            streak     <= '0;
            busyCount  <= '0;
        end else begin
            if (grantData) begin
                mem_addr  <= data_addr;
                mem_wr    <= data_wr;
                mem_wdata <= data_wdata;
                if (!inst_req) begin
                    streak <= '0;
                end else if (streak != STREAK_W'(STARVE_LIMIT)) begin
                    streak <= streak + 1'b1;
                end
            end else if (grantInst) begin
                mem_addr <= inst_addr;
                mem_wr   <= 1'b0;
                streak   <= '0;
            end

            if (done) begin
                busyCount <= '0;
                // A ready arriving on the timeout cycle still counts as a normal completion.
                if (mem_ready) begin
                    if (state == BUSY_I) begin
                        inst_rdata <= mem_rdata;
                    end else if (!mem_wr) begin
                        data_rdata <= mem_rdata;
                    end
                end else begin
                    bus_err <= 1'b1;
                    if (state == BUSY_I) begin
                        inst_rdata <= '0;
                    end else begin
                        data_rdata <= '0;
                    end
                end
            end else if (busy) begin
                busyCount <= busyCount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random phase,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ok(data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester agents: a request stays pending until the cycle after its ok.
    bit          iPend, dPend, iDone, dDone, dWr;
    logic [31:0] iAddr, dAddr, dWdata;
    int          iRepeat, dRepeat;
    bit          randomMode, doReset;

    // Reference model: one transaction with arbitration cycle txnA, txnK busy cycles,
    // ok in cycle txnA+txnK+1, next arbitration possible at txnA+txnK+2.
    bit          txnValid, txnData, txnWr, txnTimeout;
    int          txnA, txnK, txnLat;
    logic [31:0] txnAddr, txnWdata, txnRdata;
    int          freeCycle, streak;
    logic [31:0] expInstRdata, expDataRdata;
    logic        expBusErr;
    int          forceLat;
    bit          forceRdataEn;
    logic [31:0] forceRdata;
    bit          grantLog[$];
    int          reqCycles, okICount, okDCount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] packLog();
        logic [31:0] v;
        v = '0;
        foreach (grantLog[i]) v = {v[30:0], grantLog[i]};
        return v;
    endfunction

    task automatic issueInst(input logic [31:0] addr);
        iPend = 1'b1;
        iAddr = addr;
    endtask

    task automatic issueData(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        dPend  = 1'b1;
        dWr    = wr;
        dAddr  = addr;
        dWdata = wdata;
    endtask

    task automatic arbitrate();
        bit pickData;
        pickData = dPend && !(iPend && streak == STARVE_LIMIT);
        txnValid = 1'b1;
        txnA     = cyc;
        txnData  = pickData;
        if (pickData) begin
            streak   = iPend ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
            txnWr    = dWr;
            txnAddr  = dAddr;
            txnWdata = dWdata;
        end else begin
            streak   = 0;
            txnWr    = 1'b0;
            txnAddr  = iAddr;
            txnWdata = '0;
        end
        txnLat       = (forceLat >= 0) ? forceLat : int'($urandom_range(1, 6));
        txnRdata     = forceRdataEn ? forceRdata : $urandom;
        forceRdataEn = 1'b0;
        txnTimeout   = (txnLat == 0) || (txnLat > TIMEOUT);
        txnK         = txnTimeout ? TIMEOUT : txnLat;
        freeCycle    = cyc + txnK + 2;
        grantLog.push_back(pickData);
    endtask

    task automatic tick();
        logic expReq, expOkI, expOkD;
        int   n;
        bit   inFlight;
        @(negedge clk);
        cyc++;
        expReq = 1'b0;
        expOkI = 1'b0;
        expOkD = 1'b0;
        if (txnValid) begin
            n      = cyc - txnA;
            expReq = (n >= 1) && (n <= txnK);
            if (n == txnK + 1) begin
                expOkI = !txnData;
                expOkD = txnData;
                if (txnTimeout) begin
                    expBusErr = 1'b1;
                    if (txnData) expDataRdata = '0;
                    else         expInstRdata = '0;
                end else if (!txnData) begin
                    expInstRdata = txnRdata;
                end else if (!txnWr) begin
                    expDataRdata = txnRdata;
                end
            end
        end

        check("mem_req", 32'(mem_req), 32'(expReq));
        check("inst_ok", 32'(inst_ok), 32'(expOkI));
        check("data_ok", 32'(data_ok), 32'(expOkD));
        check("bus_err", 32'(bus_err), 32'(expBusErr));
        check("inst_rdata", inst_rdata, expInstRdata);
        check("data_rdata", data_rdata, expDataRdata);
        if (expReq) begin
            check("mem_addr", mem_addr, txnAddr);
            check("mem_wr", 32'(mem_wr), 32'(txnWr));
            if (txnData) check("mem_wdata", mem_wdata, txnWdata);
        end
        if (mem_req) reqCycles++;
        if (inst_ok) okICount++;
        if (data_ok) okDCount++;
        if (expOkI || expOkD) txnValid = 1'b0;

        if (iDone) begin
            iPend = 1'b0;
            if (iRepeat > 0) begin
                iRepeat--;
                issueInst(iAddr + 32'd4);
            end
        end
        if (dDone) begin
            dPend = 1'b0;
            if (dRepeat > 0) begin
                dRepeat--;
                issueData(dWr, dAddr + 32'd4, $urandom);
            end
        end
        iDone = expOkI;
        dDone = expOkD;
        if (randomMode) begin
            if (!iPend && $urandom_range(0, 1) == 1) issueInst($urandom & 32'hFFFF_FFFC);
            if (!dPend && $urandom_range(0, 2) != 0) issueData(1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        if (doReset) begin
            doReset      = 1'b0;
            rst          = 1'b1;
            iPend        = 1'b0;
            dPend        = 1'b0;
            iDone        = 1'b0;
            dDone        = 1'b0;
            iRepeat      = 0;
            dRepeat      = 0;
            txnValid     = 1'b0;
            freeCycle    = cyc + 1;
            streak       = 0;
            expInstRdata = '0;
            expDataRdata = '0;
            expBusErr    = 1'b0;
        end else begin
            rst = 1'b0;
            if (cyc >= freeCycle && (iPend || dPend)) arbitrate();
        end

        // Memory side: ready only on the chosen busy cycle, random noise when not busy.
        n = cyc - txnA;
        if (txnValid && n >= 1 && n <= txnK) begin
            mem_ready = (txnLat != 0) && (n == txnLat);
            mem_rdata = mem_ready ? txnRdata : $urandom;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end

        // Requester fields are scrambled once their transaction is in flight.
        inFlight   = txnValid && (cyc > txnA);
        inst_req   = iPend;
        inst_addr  = (iPend && !(inFlight && !txnData)) ? iAddr : $urandom;
        data_req   = dPend;
        data_wr    = (dPend && !(inFlight && txnData)) ? dWr : 1'($urandom_range(0, 1));
        data_addr  = (dPend && !(inFlight && txnData)) ? dAddr : $urandom;
        data_wdata = (dPend && !(inFlight && txnData)) ? dWdata : $urandom;
    endtask

    task automatic runUntilIdle(input int maxC, input string tag);
        int n;
        n = 0;
        while ((iPend || dPend || txnValid) && n < maxC) begin
            tick();
            n++;
        end
        check({tag, " drained"}, 32'(iPend || dPend || txnValid), 32'd0);
    endtask

    task automatic clearStats();
        grantLog.delete();
        reqCycles = 0;
        okICount  = 0;
        okDCount  = 0;
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_addr = '0; data_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        iPend = 0; dPend = 0; iDone = 0; dDone = 0; iRepeat = 0; dRepeat = 0;
        randomMode = 0; doReset = 0; txnValid = 0; streak = 0; freeCycle = 0;
        expInstRdata = '0; expDataRdata = '0; expBusErr = 1'b0;
        forceLat = -1; forceRdataEn = 0; forceRdata = '0;
        clearStats();

        repeat (3) @(negedge clk);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_wr", 32'(mem_wr), 32'd0);
        check("rst inst_ok", 32'(inst_ok), 32'd0);
        check("rst data_ok", 32'(data_ok), 32'd0);
        check("rst bus_err", 32'(bus_err), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst inst_rdata", inst_rdata, 32'd0);
        check("rst data_rdata", data_rdata, 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Single fetch, ready on the third busy cycle.
        clearStats();
        forceLat = 3; forceRdataEn = 1; forceRdata = 32'h2408_0001;
        issueInst(32'hBFC0_0000);
        tick();
        tick();
        check("fetch mem_addr", mem_addr, 32'hBFC0_0000);
        check("fetch mem_wr", 32'(mem_wr), 32'd0);
        runUntilIdle(20, "fetch");
        check("fetch inst_rdata", inst_rdata, 32'h2408_0001);
        check("fetch inst_ok count", 32'(okICount), 32'd1);
        check("fetch data_ok count", 32'(okDCount), 32'd0);
        forceLat = -1;

        // Simultaneous requests: data served first.
        clearStats();
        forceRdataEn = 1; forceRdata = 32'hDEAD_BEEF;
        issueData(1'b0, 32'h0000_0010, 32'h0);
        issueInst(32'hBFC0_0004);
        runUntilIdle(40, "simul");
        check("simul data_rdata", data_rdata, 32'hDEAD_BEEF);
        check("simul grant count", 32'(grantLog.size()), 32'd2);
        check("simul grant order", packLog(), 32'b10);

        // Starvation: D D D D I, streak restarts, D D D D I, then the remaining data.
        clearStats();
        issueInst(32'hBFC0_0100); iRepeat = 1;
        issueData(1'b0, 32'h0000_0100, 32'h0); dRepeat = 9;
        runUntilIdle(400, "starve");
        check("starve grant count", 32'(grantLog.size()), 32'd12);
        check("starve grant order", packLog(), 32'hF7B);

        // Store leaves data_rdata untouched.
        clearStats();
        forceRdataEn = 1; forceRdata = 32'h1357_2468;
        issueData(1'b0, 32'h0000_0050, 32'h0);
        runUntilIdle(20, "preload");
        issueData(1'b1, 32'h0000_0054, 32'h0000_0007);
        tick();
        tick();
        check("store mem_wr", 32'(mem_wr), 32'd1);
        check("store mem_wdata", mem_wdata, 32'h0000_0007);
        runUntilIdle(20, "store");
        check("store data_rdata kept", data_rdata, 32'h1357_2468);
        check("store data_ok count", 32'(okDCount), 32'd2);

        // Ready on the last allowed cycle is a normal completion.
        clearStats();
        forceLat = TIMEOUT; forceRdataEn = 1; forceRdata = 32'h0BAD_F00D;
        issueData(1'b0, 32'h0000_0060, 32'h0);
        runUntilIdle(30, "coincide");
        check("coincide bus_err", 32'(bus_err), 32'd0);
        check("coincide data_rdata", data_rdata, 32'h0BAD_F00D);
        check("coincide busy cycles", 32'(reqCycles), 32'(TIMEOUT));

        // Timeout: memory never answers.
        clearStats();
        forceLat = 0;
        issueData(1'b0, 32'h0000_0200, 32'h0);
        runUntilIdle(30, "timeout");
        check("timeout busy cycles", 32'(reqCycles), 32'(TIMEOUT));
        check("timeout bus_err", 32'(bus_err), 32'd1);
        check("timeout data_rdata", data_rdata, 32'd0);
        check("timeout data_ok count", 32'(okDCount), 32'd1);
        forceLat = 2; forceRdataEn = 1; forceRdata = 32'h1111_2222;
        issueInst(32'hBFC0_0200);
        runUntilIdle(20, "after timeout");
        check("after timeout inst_rdata", inst_rdata, 32'h1111_2222);
        check("after timeout bus_err", 32'(bus_err), 32'd1);
        forceLat = -1;

        // Random traffic.
        randomMode = 1;
        repeat (600) tick();
        randomMode = 0;
        runUntilIdle(60, "random");

        // Reset in the middle of a data transaction with a nonzero streak.
        clearStats();
        forceLat = 0;
        issueInst(32'hBFC0_0400);
        issueData(1'b0, 32'h0000_0300, 32'h0); dRepeat = 3;
        begin
            int n;
            n = 0;
            while (grantLog.size() < 3 && n < 200) begin
                tick();
                n++;
            end
        end
        check("reset setup grants", 32'(grantLog.size()), 32'd3);
        tick();
        tick();
        check("pre-reset mem_req", 32'(mem_req), 32'd1);
        doReset = 1;
        tick();
        okICount = 0;
        okDCount = 0;
        tick();
        check("post-reset mem_req", 32'(mem_req), 32'd0);
        check("post-reset bus_err", 32'(bus_err), 32'd0);
        check("post-reset mem_addr", mem_addr, 32'd0);
        check("post-reset mem_wr", 32'(mem_wr), 32'd0);
        check("post-reset mem_wdata", mem_wdata, 32'd0);
        check("post-reset data_rdata", data_rdata, 32'd0);
        forceLat = -1;
        repeat (12) tick();
        check("abandoned data_ok count", 32'(okDCount), 32'd0);
        check("abandoned inst_ok count", 32'(okICount), 32'd0);

        // A cleared streak gives data four grants again before fetch.
        clearStats();
        issueInst(32'hBFC0_0500);
        issueData(1'b0, 32'h0000_0400, 32'h0); dRepeat = 4;
        runUntilIdle(200, "post-reset streak");
        check("post-reset grant order", packLog(), 32'b111101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
